// File: rtl/simple_bus_mem_responder_if.sv
// ============================================================================
//  Module      : simple_bus_mem_responder_if
//  Description : simple_bus request/grant command bus between a cpu-side
//                initiator (master) and a memory-side responder (slave).
//                Signals:
//                  req      initiator requests bus
//                  gnt      responder grants bus
//                  start    one-cycle command strobe (valid while gnt=1)
//                  mode     00 nop, 01 read, 10 write, 11 burst read
//                  addr     command address
//                  data_in  write data, sampled with start
//                  data_out read data, valid when rdy=1
//                  rdy      one-cycle completion/beat strobe
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface simple_bus_mem_responder_if;
    logic       req;
    logic       gnt;
    logic       start;
    logic [1:0] mode;
    logic [7:0] addr;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       rdy;

    modport master (
        output req, start, mode, addr, data_in,
        input  gnt, data_out, rdy
    );

    modport slave (
        input  req, start, mode, addr, data_in,
        output gnt, data_out, rdy
    );
endinterface

`default_nettype wire

// File: rtl/simple_bus_mem_responder.sv
// ============================================================================
//  Module      : simple_bus_mem_responder
//  Description : Memory-side responder for the simple_bus request/grant
//                protocol. Grants the initiator, accepts one command per
//                start pulse, reads/writes an internal 256x8 array and
//                signals completion with a one-cycle rdy strobe.
//  Ports       : clk  - clock, rising edge
//                rst  - synchronous reset, active high
//                bus  - simple_bus_mem_responder_if.slave (req/gnt/start/
//                       mode/addr/data_in/data_out/rdy)
//  Parameters  : WAIT_CYCLES - wait states between start and first rdy (0..15)
//                GNT_TIMEOUT - idle cycles with gnt held before withdrawal (>=1)
//  Config      : `define SIMPLE_BUS_MEM_BURST_EN to make mode 11 a 4-beat
//                wrapping burst read; otherwise mode 11 behaves as nop.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module simple_bus_mem_responder #(
    parameter int WAIT_CYCLES = 2,
    parameter int GNT_TIMEOUT = 16
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    simple_bus_mem_responder_if.slave bus
);

    localparam int              c_IDLE_W    = (GNT_TIMEOUT > 1) ? $clog2(GNT_TIMEOUT) : 1;
    localparam logic [c_IDLE_W-1:0] c_IDLE_LAST = c_IDLE_W'(GNT_TIMEOUT - 1);
    // The WAIT state is left on the edge that sees a zero count, so the
    // counter is preloaded one short of the wait-state count.
    localparam logic [3:0]      c_WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    localparam logic [1:0] c_MODE_NOP   = 2'b00;
    localparam logic [1:0] c_MODE_READ  = 2'b01;
    localparam logic [1:0] c_MODE_WRITE = 2'b10;
    localparam logic [1:0] c_MODE_BURST = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANTED = 2'd1,
        ST_WAIT    = 2'd2,
        ST_XFER    = 2'd3
    } state_t;

    state_t              r_state;
    logic [c_IDLE_W-1:0] r_idle_cnt;
    logic [3:0]          r_wait_cnt;
    logic [1:0]          r_mode;
    logic [7:0]          r_addr;
    logic [7:0]          r_wdata;
    logic                r_gnt;
    logic                r_rdy;
    logic [7:0]          r_data_out;
    logic [7:0]          r_mem [256];

    logic                w_is_read;
    logic                w_burst_more;
    logic                w_mem_we;

`ifdef SIMPLE_BUS_MEM_BURST_EN
    logic [1:0]          r_beat;

    assign w_is_read    = (r_mode == c_MODE_READ) || (r_mode == c_MODE_BURST);
    assign w_burst_more = (r_mode == c_MODE_BURST) && (r_beat != 2'd3);
`else
    assign w_is_read    = (r_mode == c_MODE_READ);
    assign w_burst_more = 1'b0;
`endif

    // Writes land only on the XFER edge; a reset before then drops them.
    assign w_mem_we = (r_state == ST_XFER) && (r_mode == c_MODE_WRITE) && !rst;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_addr] <= r_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_idle_cnt <= '0;
            r_wait_cnt <= 4'd0;
            r_mode     <= c_MODE_NOP;
            r_addr     <= 8'h00;
            r_wdata    <= 8'h00;
            r_gnt      <= 1'b0;
            r_rdy      <= 1'b0;
            r_data_out <= 8'h00;
`ifdef SIMPLE_BUS_MEM_BURST_EN
            r_beat     <= 2'd0;
`endif
        end else begin
            r_rdy <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_idle_cnt <= '0;
                    if (bus.req) begin
                        r_state <= ST_GRANTED;
                        r_gnt   <= 1'b1;
                    end
                end

                ST_GRANTED: begin
                    if (bus.start) begin
                        r_mode     <= bus.mode;
                        r_addr     <= bus.addr;
                        r_wdata    <= bus.data_in;
                        r_wait_cnt <= c_WAIT_LOAD;
                        r_idle_cnt <= '0;
`ifdef SIMPLE_BUS_MEM_BURST_EN
                        r_beat     <= 2'd0;
`endif
                        r_state    <= (WAIT_CYCLES == 0) ? ST_XFER : ST_WAIT;
                    end else if (!bus.req || (r_idle_cnt == c_IDLE_LAST)) begin
                        r_state    <= ST_IDLE;
                        r_gnt      <= 1'b0;
                        r_idle_cnt <= '0;
                    end else begin
                        r_idle_cnt <= r_idle_cnt + 1'b1;
                    end
                end

                ST_WAIT: begin
                    if (r_wait_cnt == 4'd0) begin
                        r_state <= ST_XFER;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end
                end

                ST_XFER: begin
                    // rdy and read data become visible in the cycle after
                    // this edge; nop and write leave data_out untouched.
                    r_rdy <= 1'b1;
                    if (w_is_read) begin
                        r_data_out <= r_mem[r_addr];
                    end
                    if (w_burst_more) begin
                        r_addr <= r_addr + 8'd1;
`ifdef SIMPLE_BUS_MEM_BURST_EN
                        r_beat <= r_beat + 2'd1;
`endif
                    end else if (bus.req) begin
                        r_state    <= ST_GRANTED;
                        r_idle_cnt <= '0;
                    end else begin
                        r_state <= ST_IDLE;
                        r_gnt   <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt      = r_gnt;
    assign bus.rdy      = r_rdy;
    assign bus.data_out = r_data_out;

endmodule

`default_nettype wire

// File: tb/tb_simple_bus_mem_responder.sv
// ============================================================================
//  Module      : tb_simple_bus_mem_responder
//  Description : Scoreboard bench for simple_bus_mem_responder. The driver
//                issues commands and pushes the expected rdy beats (edge
//                number and data_out) computed from a plain array model;
//                a negedge monitor pops and compares on every rdy.
//                Honours SIMPLE_BUS_MEM_BURST_EN the same way as the design.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_simple_bus_mem_responder;

    localparam int WAIT_CYCLES = 2;
    localparam int GNT_TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    simple_bus_mem_responder_if bus ();

    simple_bus_mem_responder #(
        .WAIT_CYCLES (WAIT_CYCLES),
        .GNT_TIMEOUT (GNT_TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int         cyc;
        logic [7:0] data;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    logic [7:0] ref_mem [256];
    logic [7:0] last_rd;
    int         edge_n      = 0;
    int         vectors     = 0;
    int         miscompares = 0;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string name, input int act, input int want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, want, edge_n);
        end
    endtask

    // Monitor: every rdy beat must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && bus.rdy) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_rdy: rdy=1 at edge %0d, expected no beat", edge_n);
            end else begin
                mon_e = sb.pop_front();
                chk("rdy_edge", edge_n, mon_e.cyc);
                chk("data_out", int'(bus.data_out), int'(mon_e.data));
            end
        end
    end

    task automatic push_exp(input int c, input logic [7:0] d);
        exp_t e;
        e.cyc  = c;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic wait_drain(input bit check_gnt);
        int budget;
        budget = 0;
        while (sb.size() != 0 && budget < 40) begin
            @(negedge clk);
            if (check_gnt) chk("gnt_held", int'(bus.gnt), 1);
            budget++;
        end
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d beats outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    // Issue one command from GRANTED; the model decides the beats.
    task automatic do_cmd(input logic [1:0] m, input logic [7:0] a,
                          input logic [7:0] d, input bit drop_req);
        int         t;
        logic [7:0] la;
        @(negedge clk);
        chk("gnt_before_start", int'(bus.gnt), 1);
        bus.start   = 1'b1;
        bus.mode    = m;
        bus.addr    = a;
        bus.data_in = d;
        t = edge_n + 1;
        case (m)
            2'b01: begin
                last_rd = ref_mem[a];
                push_exp(t + WAIT_CYCLES + 1, last_rd);
            end
            2'b10: begin
                ref_mem[a] = d;
                push_exp(t + WAIT_CYCLES + 1, last_rd);
            end
            2'b11: begin
`ifdef SIMPLE_BUS_MEM_BURST_EN
                for (int k = 0; k < 4; k++) begin
                    la      = a + 8'(k);
                    last_rd = ref_mem[la];
                    push_exp(t + WAIT_CYCLES + 1 + k, last_rd);
                end
`else
                push_exp(t + WAIT_CYCLES + 1, last_rd);
`endif
            end
            default: push_exp(t + WAIT_CYCLES + 1, last_rd);
        endcase
        @(negedge clk);
        bus.start = 1'b0;
        if (drop_req) bus.req = 1'b0;
        wait_drain(!drop_req);
        if (drop_req) chk("gnt_after_drop", int'(bus.gnt), 0);
    endtask

    task automatic regrant();
        @(negedge clk);
        bus.req = 1'b1;
        @(negedge clk);
        chk("gnt_regrant", int'(bus.gnt), 1);
    endtask

    initial begin
        rst         = 1'b1;
        bus.req     = 1'b0;
        bus.start   = 1'b0;
        bus.mode    = 2'b00;
        bus.addr    = 8'h00;
        bus.data_in = 8'h00;
        last_rd     = 8'h00;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;

        repeat (3) @(negedge clk);
        chk("reset_gnt", int'(bus.gnt), 0);
        chk("reset_rdy", int'(bus.rdy), 0);
        chk("reset_data_out", int'(bus.data_out), 0);

        rst     = 1'b0;
        bus.req = 1'b1;
        @(negedge clk);
        chk("gnt_after_req", int'(bus.gnt), 1);
        chk("rdy_after_req", int'(bus.rdy), 0);
        chk("data_out_after_req", int'(bus.data_out), 0);

        // Directed write/read pair, back to back with req held.
        do_cmd(2'b10, 8'h10, 8'hA5, 1'b0);
        do_cmd(2'b01, 8'h10, 8'h00, 1'b0);

        // Give every location a known value.
        for (int i = 0; i < 256; i++) begin
            do_cmd(2'b10, 8'(i), 8'($urandom), 1'b0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Burst across the 8'hFF -> 8'h00 wrap.
        do_cmd(2'b10, 8'hFE, 8'h11, 1'b0);
        do_cmd(2'b10, 8'hFF, 8'h22, 1'b0);
        do_cmd(2'b10, 8'h00, 8'h33, 1'b0);
        do_cmd(2'b10, 8'h01, 8'h44, 1'b0);
        do_cmd(2'b01, 8'h80, 8'h00, 1'b0);
        do_cmd(2'b11, 8'hFE, 8'h00, 1'b0);

        // Random traffic; occasionally drop req mid-command.
        repeat (150) begin
            logic [1:0] m;
            bit         drop;
            m    = 2'($urandom_range(0, 3));
            drop = ($urandom_range(0, 7) == 0);
            do_cmd(m, 8'($urandom), 8'($urandom), drop);
            if (drop) regrant();
            else repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Reset during WAIT aborts a pending write.
        do_cmd(2'b10, 8'h20, 8'h3C, 1'b0);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.mode    = 2'b10;
        bus.addr    = 8'h20;
        bus.data_in = 8'h5A;
        @(negedge clk);
        bus.start = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        chk("abort_gnt", int'(bus.gnt), 0);
        chk("abort_rdy", int'(bus.rdy), 0);
        chk("abort_data_out", int'(bus.data_out), 0);
        last_rd = 8'h00;
        rst     = 1'b0;
        @(negedge clk);
        chk("abort_regrant", int'(bus.gnt), 1);
        do_cmd(2'b01, 8'h20, 8'h00, 1'b0);

        // Grant timeout, then a start while not granted is ignored.
        bus.req = 1'b0;
        repeat (2) @(negedge clk);
        bus.req = 1'b1;
        for (int i = 0; i < GNT_TIMEOUT; i++) begin
            @(negedge clk);
            chk("gnt_timeout_hold", int'(bus.gnt), 1);
        end
        @(negedge clk);
        chk("gnt_timeout_drop", int'(bus.gnt), 0);
        bus.req   = 1'b0;
        bus.start = 1'b1;
        bus.mode  = 2'b01;
        bus.addr  = 8'h10;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) begin
            @(negedge clk);
            chk("start_ignored_gnt", int'(bus.gnt), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
